stream_upsize_flush: RTL and testbench

Width-upsizing stream converter. It packs `T_DATA_RATIO` narrow input beats into one wide output word, with `m_keep_o` lane qualifiers. It is the full-throughput successor to the single-register upsizer:

- a separate accumulator and output register sustain one input beat per clock;
- lane order is selectable;
- an optional idle-timeout flush emits a partially filled word when the input stalls mid-word.

It sits between narrow producers (byte and halfword sources) and wide packet datapaths.

---
 rtl/stream_upsize_flush.sv | 129 ++++++++++++
 tb/tb_stream_upsize_flush.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize_flush.sv
// Width-upsizing stream converter: packs T_DATA_RATIO narrow beats into one wide word
// with a lane keep mask, selectable lane order and an optional idle-timeout partial flush.
module stream_upsize_flush #(
  parameter int unsigned T_DATA_WIDTH  = 8,
  parameter int unsigned T_DATA_RATIO  = 4,
  parameter int unsigned T_WIDTH_RATIO = $clog2(T_DATA_RATIO),
  parameter int unsigned PACK_ORDER    = 0,
  parameter int unsigned FLUSH_TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned CW = T_WIDTH_RATIO + 1;
  localparam int unsigned IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(T_DATA_RATIO - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);

  logic [T_DATA_WIDTH-1:0] acc_q  [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] acc_d  [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] word_c [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] keep_q, keep_d, keep_c;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;
  logic                    slot_free, hs, flush, load;

  // Beat index that lands in a given lane.
  function automatic logic [CW-1:0] beat_of(input int unsigned lane);
    if (PACK_ORDER != 0) return CW'(T_DATA_RATIO - 1 - lane);
    return CW'(lane);
  endfunction

  assign s_ready_o = slot_free;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;
  assign m_valid_o = valid_q;

  // Next-state: accumulate, complete, flush, retire.
  always_comb begin
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    keep_c  = '0;

    slot_free = ~valid_q | m_ready_i;
    hs        = s_valid_i & slot_free;
    flush     = (FLUSH_TIMEOUT != 0) && !hs && (cnt_q != '0) &&
                (idle_q == IDLE_MAX) && slot_free;
    load      = (hs & ((cnt_q == CNT_LAST) | s_last_i)) | flush;

    // Candidate output word: held lanes, the incoming beat, zeros beyond.
    for (int unsigned l = 0; l < T_DATA_RATIO; l++) begin
      if (beat_of(l) < cnt_q) begin
        word_c[l] = acc_q[l];
        keep_c[l] = 1'b1;
      end else if ((beat_of(l) == cnt_q) && hs) begin
        word_c[l] = s_data_i;
        keep_c[l] = 1'b1;
      end else begin
        word_c[l] = '0;
      end
    end

    if (load) begin
      data_d  = word_c;
      keep_d  = keep_c;
      last_d  = hs & s_last_i;
      valid_d = 1'b1;
      cnt_d   = '0;
      for (int unsigned l = 0; l < T_DATA_RATIO; l++) acc_d[l] = '0;
    end else begin
      if (hs) begin
        for (int unsigned l = 0; l < T_DATA_RATIO; l++) begin
          if (beat_of(l) == cnt_q) acc_d[l] = s_data_i;
        end
        cnt_d = cnt_q + CW'(1);
      end
      if (valid_q & m_ready_i) valid_d = 1'b0;
    end

    // Idle counter only runs while a partial word waits for more input.
    if ((FLUSH_TIMEOUT == 0) || hs || (cnt_q == '0) || flush) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned l = 0; l < T_DATA_RATIO; l++) begin
        acc_q[l]  <= '0;
        data_q[l] <= '0;
      end
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_stream_upsize_flush.sv
// Bench for stream_upsize_flush: two instances (lane-0-first with flush, reversed without),
// directed scenarios then randomized traffic against a beat-list reference model.
module tb_stream_upsize_flush;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data  [2];
  logic       s_last  [2];
  logic       s_valid [2];
  logic       m_ready [2];

  logic       s_ready0, s_ready1, m_last0, m_last1, m_valid0, m_valid1;
  logic [3:0] m_keep0, m_keep1;
  logic [7:0] m_data0 [R-1:0];
  logic [7:0] m_data1 [R-1:0];

  logic        obs_ready [2];
  logic        obs_last  [2];
  logic        obs_valid [2];
  logic [3:0]  obs_keep  [2];
  logic [31:0] obs_flat  [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state: outstanding beats plus the presented word.
  bit          mv   [2];
  logic [31:0] md   [2];
  logic [3:0]  mk   [2];
  bit          ml   [2];
  logic [7:0]  pbuf [2][R];
  int          pcnt [2];
  int          idle [2];
  bit          took [2];
  bit          model_ok = 1'b0;

  stream_upsize_flush #(.T_DATA_WIDTH(8), .T_DATA_RATIO(R), .PACK_ORDER(0), .FLUSH_TIMEOUT(3)) u_dut0 (
    .clk(clk), .rst(rst), .s_data_i(s_data[0]), .s_last_i(s_last[0]), .s_valid_i(s_valid[0]),
    .s_ready_o(s_ready0), .m_data_o(m_data0), .m_keep_o(m_keep0), .m_last_o(m_last0),
    .m_valid_o(m_valid0), .m_ready_i(m_ready[0]));

  stream_upsize_flush #(.T_DATA_WIDTH(8), .T_DATA_RATIO(R), .PACK_ORDER(1), .FLUSH_TIMEOUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .s_data_i(s_data[1]), .s_last_i(s_last[1]), .s_valid_i(s_valid[1]),
    .s_ready_o(s_ready1), .m_data_o(m_data1), .m_keep_o(m_keep1), .m_last_o(m_last1),
    .m_valid_o(m_valid1), .m_ready_i(m_ready[1]));

  always #5 clk = ~clk;

  always_comb begin
    obs_ready[0] = s_ready0;  obs_ready[1] = s_ready1;
    obs_last[0]  = m_last0;   obs_last[1]  = m_last1;
    obs_valid[0] = m_valid0;  obs_valid[1] = m_valid1;
    obs_keep[0]  = m_keep0;   obs_keep[1]  = m_keep1;
    obs_flat[0]  = {m_data0[3], m_data0[2], m_data0[1], m_data0[0]};
    obs_flat[1]  = {m_data1[3], m_data1[2], m_data1[1], m_data1[0]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset(input int i);
    mv[i] = 1'b0; md[i] = '0; mk[i] = '0; ml[i] = 1'b0;
    pcnt[i] = 0; idle[i] = 0; took[i] = 1'b1;
  endfunction

  function automatic void model_step(input int i);
    int t;
    bit sf, hs, ld, lv;
    int lane;
    t  = (i == 0) ? 3 : 0;
    sf = !mv[i] || (m_ready[i] == 1'b1);
    hs = (s_valid[i] == 1'b1) && sf;
    ld = 1'b0;
    lv = 1'b0;
    took[i] = hs;
    if (hs) begin
      pbuf[i][pcnt[i]] = s_data[i];
      pcnt[i]++;
      idle[i] = 0;
      if (pcnt[i] == R || s_last[i] == 1'b1) begin
        ld = 1'b1;
        lv = s_last[i];
      end
    end else if (t > 0) begin
      if (pcnt[i] == 0) idle[i] = 0;
      else if (idle[i] == t && sf) begin
        ld = 1'b1;
        idle[i] = 0;
      end else if (idle[i] < t) idle[i]++;
    end
    if (ld) begin
      md[i] = '0;
      mk[i] = '0;
      for (int j = 0; j < pcnt[i]; j++) begin
        lane = (i == 1) ? R - 1 - j : j;
        md[i][lane*8 +: 8] = pbuf[i][j];
        mk[i][lane] = 1'b1;
      end
      ml[i]   = lv;
      mv[i]   = 1'b1;
      pcnt[i] = 0;
    end else if (mv[i] && m_ready[i] == 1'b1) begin
      mv[i] = 1'b0;
    end
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    #1;
    if (model_ok)
      for (int i = 0; i < 2; i++)
        check($sformatf("dut%0d s_ready", i), 32'(obs_ready[i]), 32'(!mv[i] || m_ready[i] == 1'b1));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst == 1'b1) begin
        model_reset(i);
        model_ok = 1'b1;
      end else if (model_ok) begin
        model_step(i);
      end
    end
    #1;
    if (model_ok)
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d m_valid", i), 32'(obs_valid[i]), 32'(mv[i]));
        check($sformatf("dut%0d m_keep", i), 32'(obs_keep[i]), 32'(mk[i]));
        check($sformatf("dut%0d m_last", i), 32'(obs_last[i]), 32'(ml[i]));
        check($sformatf("dut%0d m_data", i), obs_flat[i], md[i]);
      end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit r);
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = v; s_data[i] = d; s_last[i] = l; m_ready[i] = r;
    end
    cycle();
  endtask

  task automatic rand_inputs(input int pv, input int pr, input int pl);
    for (int i = 0; i < 2; i++) begin
      if (!(s_valid[i] == 1'b1 && !took[i])) begin
        s_valid[i] = (int'($urandom_range(99)) < pv);
        s_data[i]  = 8'($urandom);
        s_last[i]  = (int'($urandom_range(99)) < pl);
      end
      m_ready[i] = (int'($urandom_range(99)) < pr);
    end
    rst = ($urandom_range(999) == 0);
  endtask

  initial begin
    int pv_t [5] = '{90, 50, 20, 95, 70};
    int pr_t [5] = '{90, 50, 80, 30, 100};
    int pl_t [5] = '{10, 20, 5, 10, 40};
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; s_data[i] = '0; s_last[i] = 1'b0; m_ready[i] = 1'b1; took[i] = 1'b1;
    end
    @(negedge clk);
    drive(0, 8'h00, 0, 1);
    rst = 1'b0;
    check("reset keep", 32'(m_keep0), 32'h0);

    // Full words on consecutive cycles.
    for (int k = 1; k <= 4; k++) drive(1, 8'(k * 17), 0, 1);
    check("full0 valid", 32'(m_valid0), 32'h1);
    check("full0 data", obs_flat[0], 32'h44332211);
    check("full0 keep", 32'(m_keep0), 32'hF);
    for (int k = 5; k <= 8; k++) drive(1, 8'(k * 17), 0, 1);
    check("full1 data", obs_flat[0], 32'h88776655);

    // Short last word.
    drive(1, 8'hA1, 0, 1);
    drive(1, 8'hA2, 1, 1);
    check("short data", obs_flat[0], 32'h0000A2A1);
    check("short keep", 32'(m_keep0), 32'h3);
    check("short last", 32'(m_last0), 32'h1);

    // Reversed lane order.
    drive(1, 8'h01, 0, 1);
    drive(1, 8'h02, 0, 1);
    drive(1, 8'h03, 1, 1);
    check("rev data", obs_flat[1], 32'h01020300);
    check("rev keep", 32'(m_keep1), 32'hE);

    // Back-pressure, then retire and reload on the same edge.
    drive(0, 8'h00, 0, 1);
    for (int k = 1; k <= 4; k++) drive(1, 8'(8'hE0 + k), 0, 0);
    for (int k = 0; k < 5; k++) drive(1, 8'hF1, 1, 0);
    check("bp ready", 32'(s_ready0), 32'h0);
    check("bp data", obs_flat[0], 32'hE4E3E2E1);
    drive(1, 8'hF1, 1, 1);
    check("reload valid", 32'(m_valid0), 32'h1);
    check("reload data", obs_flat[0], 32'h000000F1);
    drive(0, 8'h00, 0, 1);

    // Idle-timeout flush of a two-beat partial word.
    drive(1, 8'h61, 0, 1);
    drive(1, 8'h62, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 8'h00, 0, 1);
      if (k == 3) check("flush early", 32'(m_valid0), 32'h0);
    end
    check("flush valid", 32'(m_valid0), 32'h1);
    check("flush keep", 32'(m_keep0), 32'h3);
    check("flush last", 32'(m_last0), 32'h0);
    check("flush data", obs_flat[0], 32'h00006261);
    drive(0, 8'h00, 0, 1);

    // A beat in the timeout cycle is appended instead of flushing.
    drive(1, 8'h71, 0, 1);
    drive(1, 8'h72, 0, 1);
    for (int k = 0; k < 3; k++) drive(0, 8'h00, 0, 1);
    check("noflush valid", 32'(m_valid0), 32'h0);
    drive(1, 8'h73, 1, 1);
    check("append keep", 32'(m_keep0), 32'h7);
    check("append data", obs_flat[0], 32'h00737271);
    drive(0, 8'h00, 0, 1);

    // Reset mid-fill discards the partial word.
    drive(1, 8'hD1, 0, 1);
    drive(1, 8'hD2, 0, 1);
    rst = 1'b1;
    drive(0, 8'h00, 0, 1);
    rst = 1'b0;
    check("rst data", obs_flat[0], 32'h0);
    for (int k = 1; k <= 4; k++) drive(1, 8'(8'hC0 + k), 0, 1);
    check("post-rst data", obs_flat[0], 32'hC4C3C2C1);
    check("post-rst keep", 32'(m_keep0), 32'hF);
    drive(0, 8'h00, 0, 1);

    // Randomized traffic in phases of differing load.
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < 400; c++) begin
        rand_inputs(pv_t[ph], pr_t[ph], pl_t[ph]);
        cycle();
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
